// File: rtl/bolme_hakemi.sv
// Two-requester front end for a shared multi-cycle divide unit: round-robin accept,
// one start pulse per operation, bounded wait for completion and held result handshake.
module bolme_hakemi #(
  parameter int ZAMANASIMI_SINIR = 64
) (
  input  logic        clk_g,
  input  logic        rstn_g,
  input  logic        istek0_gecerli_g,
  output logic        istek0_hazir_c,
  input  logic [3:0]  istek0_islev_kodu_g,
  input  logic [31:0] istek0_islec1_g,
  input  logic [31:0] istek0_islec2_g,
  input  logic        istek1_gecerli_g,
  output logic        istek1_hazir_c,
  input  logic [3:0]  istek1_islev_kodu_g,
  input  logic [31:0] istek1_islec1_g,
  input  logic [31:0] istek1_islec2_g,
  output logic        sonuc0_gecerli_c,
  input  logic        sonuc0_hazir_g,
  output logic [31:0] sonuc0_c,
  output logic        sonuc0_hata_c,
  output logic        sonuc1_gecerli_c,
  input  logic        sonuc1_hazir_g,
  output logic [31:0] sonuc1_c,
  output logic        sonuc1_hata_c,
  output logic        bb_hazir_c,
  output logic [3:0]  bb_islev_kodu_c,
  output logic [31:0] bb_islec1_c,
  output logic [31:0] bb_islec2_c,
  input  logic        bb_bitti_g,
  input  logic [31:0] bb_sonuc_g,
  output logic        mesgul_c
);

  localparam int SW = (ZAMANASIMI_SINIR > 2) ? $clog2(ZAMANASIMI_SINIR) : 1;
  localparam logic [SW-1:0] SAYAC_SON = SW'(ZAMANASIMI_SINIR - 1);

  typedef enum logic [1:0] {BOSTA, BASLAT, BEKLE, TESLIM} durum_t;

  durum_t        durum_q, durum_d;
  logic [3:0]    islev_q, islev_d;
  logic [31:0]   islec1_q, islec1_d;
  logic [31:0]   islec2_q, islec2_d;
  logic [31:0]   sonuc_q, sonuc_d;
  logic          hata_q, hata_d;
  logic          sahip_q, sahip_d;
  logic          son_q, son_d;
  logic [SW-1:0] sayac_q, sayac_d;

  logic          kazanan;
  logic [3:0]    secilen_islev;
  logic          kabul;
  logic          teslim_hazir;

  // son_q holds the requester served last; it resets to 1 so requester 0 wins first.
  always_comb begin
    kazanan = 1'b0;
    if (istek0_gecerli_g && istek1_gecerli_g) kazanan = ~son_q;
    else if (istek1_gecerli_g)                kazanan = 1'b1;
  end

  assign istek0_hazir_c = rstn_g && (durum_q == BOSTA) && istek0_gecerli_g && !kazanan;
  assign istek1_hazir_c = rstn_g && (durum_q == BOSTA) && istek1_gecerli_g && kazanan;
  assign kabul          = istek0_hazir_c || istek1_hazir_c;
  assign secilen_islev  = kazanan ? istek1_islev_kodu_g : istek0_islev_kodu_g;
  assign teslim_hazir   = sahip_q ? sonuc1_hazir_g : sonuc0_hazir_g;

  always_comb begin
    durum_d  = durum_q;
    islev_d  = islev_q;
    islec1_d = islec1_q;
    islec2_d = islec2_q;
    sonuc_d  = sonuc_q;
    hata_d   = hata_q;
    sahip_d  = sahip_q;
    son_d    = son_q;
    sayac_d  = sayac_q;
    case (durum_q)
      BOSTA: begin
        if (kabul) begin
          islev_d  = secilen_islev;
          islec1_d = kazanan ? istek1_islec1_g : istek0_islec1_g;
          islec2_d = kazanan ? istek1_islec2_g : istek0_islec2_g;
          sahip_d  = kazanan;
          if (secilen_islev == 4'd1 || secilen_islev == 4'd2 ||
              secilen_islev == 4'd4 || secilen_islev == 4'd8) begin
            durum_d = BASLAT;
          end else begin
            sonuc_d = '0;
            hata_d  = 1'b1;
            durum_d = TESLIM;
          end
        end
      end
      BASLAT: begin
        sayac_d = '0;
        durum_d = BEKLE;
      end
      BEKLE: begin
        if (bb_bitti_g) begin
          sonuc_d = bb_sonuc_g;
          hata_d  = 1'b0;
          durum_d = TESLIM;
        end else if (sayac_q == SAYAC_SON) begin
          sonuc_d = '0;
          hata_d  = 1'b1;
          durum_d = TESLIM;
        end else begin
          sayac_d = sayac_q + SW'(1);
        end
      end
      TESLIM: begin
        if (teslim_hazir) begin
          son_d   = sahip_q;
          durum_d = BOSTA;
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_g or negedge rstn_g) begin
    if (!rstn_g) begin
      durum_q  <= BOSTA;
      islev_q  <= '0;
      islec1_q <= '0;
      islec2_q <= '0;
      sonuc_q  <= '0;
      hata_q   <= 1'b0;
      sahip_q  <= 1'b0;
      son_q    <= 1'b1;
      sayac_q  <= '0;
    end else begin
      durum_q  <= durum_d;
      islev_q  <= islev_d;
      islec1_q <= islec1_d;
      islec2_q <= islec2_d;
      sonuc_q  <= sonuc_d;
      hata_q   <= hata_d;
      sahip_q  <= sahip_d;
      son_q    <= son_d;
      sayac_q  <= sayac_d;
    end
  end

  logic bb_aktif;
  assign bb_aktif         = (durum_q == BASLAT) || (durum_q == BEKLE);
  assign bb_hazir_c       = (durum_q == BASLAT);
  assign bb_islev_kodu_c  = bb_aktif ? islev_q  : '0;
  assign bb_islec1_c      = bb_aktif ? islec1_q : '0;
  assign bb_islec2_c      = bb_aktif ? islec2_q : '0;

  assign sonuc0_gecerli_c = (durum_q == TESLIM) && !sahip_q;
  assign sonuc1_gecerli_c = (durum_q == TESLIM) && sahip_q;
  assign sonuc0_c         = sonuc0_gecerli_c ? sonuc_q : '0;
  assign sonuc1_c         = sonuc1_gecerli_c ? sonuc_q : '0;
  assign sonuc0_hata_c    = sonuc0_gecerli_c && hata_q;
  assign sonuc1_hata_c    = sonuc1_gecerli_c && hata_q;
  assign mesgul_c         = (durum_q != BOSTA);

endmodule

// File: doc/bolme_hakemi.md
BOLME_HAKEMI -- requirements
Module: bolme_hakemi

Interface
REQ-001 The block SHALL have parameter ZAMANASIMI_SINIR, default 64, meaning the maximum number of BEKLE cycles allowed before bb_bitti_g.
REQ-002 The block SHALL have port clk_g, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstn_g, input, 1 bit: reset, asynchronous and active-low.
REQ-004 For each requester i in {0,1}, the block SHALL have istek<i>_gecerli_g, input, 1 bit: request valid.
REQ-005 For each i, the block SHALL have istek<i>_hazir_c, output, 1 bit: request accepted this cycle.
REQ-006 For each i, the block SHALL have istek<i>_islev_kodu_g (input, 4 bits), plus istek<i>_islec1_g and istek<i>_islec2_g (inputs, 32 bits each): opcode (DIV=1, DIVU=2, REM=4, REMU=8), dividend, divisor.
REQ-007 For each i, the block SHALL have sonuc<i>_gecerli_c (output, 1 bit), sonuc<i>_hazir_g (input, 1 bit), sonuc<i>_c (output, 32 bits) and sonuc<i>_hata_c (output, 1 bit): result handshake, data and error flag.
REQ-008 The block SHALL have bb_hazir_c (output, 1 bit), bb_islev_kodu_c (output, 4 bits), bb_islec1_c and bb_islec2_c (outputs, 32 bits each): start pulse and operands to the divide unit.
REQ-009 The block SHALL have bb_bitti_g (input, 1 bit) and bb_sonuc_g (input, 32 bits): divide unit done flag and result, with the result valid in the bitti cycle.
REQ-010 The block SHALL have mesgul_c, output, 1 bit: high whenever the FSM is not in BOSTA.

Function
REQ-011 The FSM SHALL have exactly four states: BOSTA, BASLAT, BEKLE and TESLIM.
REQ-012 In BOSTA, the block SHALL raise istek<i>_hazir_c only for the arbitration winner, and only if that requester's gecerli is high; at most one hazir SHALL be high; both SHALL be 0 in every other state.
REQ-013 Arbitration SHALL be round-robin: on simultaneous requests, the requester not served last wins; after reset, requester 0 has priority.
REQ-014 On an accepted request (gecerli and hazir both high), the block SHALL latch the opcode, both operands and the owner id, and go to BASLAT; if the opcode is not one of 1, 2, 4 or 8, it SHALL go directly to TESLIM with result 0 and hata 1, and issue no bb_hazir_c.
REQ-015 In BASLAT, the block SHALL assert bb_hazir_c for exactly one cycle, clear the timeout counter and go to BEKLE.
REQ-016 bb_islev_kodu_c, bb_islec1_c and bb_islec2_c SHALL drive the latched values from BASLAT until the block leaves BEKLE.
REQ-017 In BEKLE, when bb_bitti_g=1, the block SHALL capture bb_sonuc_g with hata 0 and go to TESLIM.
REQ-018 In BEKLE, the counter SHALL increment each cycle; if it reaches ZAMANASIMI_SINIR-1 without bitti, the block SHALL go to TESLIM with result 0 and hata 1; bitti in that same cycle SHALL take precedence.
REQ-019 The block SHALL ignore bb_bitti_g in BOSTA, BASLAT and TESLIM.
REQ-020 In TESLIM, the block SHALL hold sonuc<owner>_gecerli_c=1 with stable sonuc and hata until sonuc<owner>_hazir_g=1; it SHALL then record the owner as last served and go to BOSTA.
REQ-021 The non-owner's sonuc_gecerli_c SHALL stay 0.
REQ-022 Latency: with the request accepted at cycle T, bb_hazir_c SHALL be high at T+1, and sonuc_gecerli_c SHALL rise the cycle after bb_bitti_g is seen.
REQ-023 A new request SHALL be accepted no earlier than the cycle after the TESLIM handshake, so there is no overlap.
REQ-024 The block SHALL not modify the result arithmetically; divide-by-zero and overflow values come from the divide unit.

Reset
REQ-025 While rstn_g=0, from any state, the FSM SHALL be BOSTA and all outputs 0, including latched operands, results, hata, counter and mesgul_c; the round-robin pointer SHALL favour requester 0.
REQ-026 A bb_bitti_g pulse that completes an operation aborted by reset SHALL be ignored.

Verification
REQ-027 Requester 0 sends DIV 100/7 -> bb_hazir_c is high exactly one cycle, at T+1; sonuc0_c=14 and hata=0; sonuc1_gecerli_c stays 0.
REQ-028 After reset, both requesters send in the same cycle (req0 REMU 17,5; req1 DIVU 17,5) -> req0 is served first with 2, then req1 with 3; the next simultaneous pair is served req0 first.
REQ-029 Hold sonuc0_hazir_g=0 for 10 cycles -> gecerli, sonuc and hata stay stable; both istek_hazir stay 0; mesgul_c=1.
REQ-030 Send opcode 4'h3 -> no bb_hazir_c pulse; sonuc=0 and hata=1 on the cycle after acceptance.
REQ-031 Hold bb_bitti_g=0 -> after 64 BEKLE cycles, sonuc=0 and hata=1; a later bitti is ignored.
REQ-032 Pulse rstn_g low during BEKLE, then give bb_bitti_g=1 -> all outputs are 0 and no result is produced; a new request completes normally afterwards.
